// File: rtl/pipe_ctrl_if.sv
// Purpose: bundles the ID/EX hazard inputs and the pipeline-control outputs of pipe_ctrl.
// Ports: slave = controller side (hazard/interrupt inputs in, stall/flush/PC controls out);
//        master = pipeline side (the mirror image).
interface pipe_ctrl_if;
  // hazard / interrupt inputs to the controller
  logic [4:0]  IdRs;
  logic [4:0]  IdRt;
  logic [31:0] IdPC;
  logic        IdValid;
  logic        IdEret;
  logic [4:0]  ExRd;
  logic        ExMemRead;
  logic        ExRFWr;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        IntReq;
  logic        IE;
  // pipeline control outputs from the controller
  logic        PCWrite;
  logic        IfIdWrite;
  logic        IfIdClear;
  logic        IdExClear;
  logic [1:0]  PCSrcOv;
  logic [31:0] EPC;
  logic        IntAck;
  logic        InService;

  modport master (
    output IdRs, IdRt, IdPC, IdValid, IdEret, ExRd, ExMemRead, ExRFWr,
           BranchTaken, BranchTarget, IntReq, IE,
    input  PCWrite, IfIdWrite, IfIdClear, IdExClear, PCSrcOv, EPC, IntAck, InService
  );

  modport slave (
    input  IdRs, IdRt, IdPC, IdValid, IdEret, ExRd, ExMemRead, ExRFWr,
           BranchTaken, BranchTarget, IntReq, IE,
    output PCWrite, IfIdWrite, IfIdClear, IdExClear, PCSrcOv, EPC, IntAck, InService
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline hazard + interrupt controller (load-use stall, branch flush, IRQ entry/ERET exit).
// Latency: stall/flush/ack outputs are combinational in the same cycle; FLUSH and RETURN last 1 cycle.
// Backpressure: a load-use hazard freezes PC and IF/ID and bubbles ID/EX; interrupts wait for IE && IdValid.
// Ports: clk, rst (async active-low), bus (pipe_ctrl_if.slave) carrying all hazard inputs and control outputs.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;
  localparam logic [1:0] ST_RETURN  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic        pending_q, pending_d;

  logic        lu;
  logic        accept;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_clear;
  logic        idex_clear;
  logic [1:0]  pc_src_ov;
  logic        int_ack;

  // Load-use: EX is a load writing a non-zero register that ID reads.
  assign lu = bus.ExMemRead && bus.ExRFWr && (bus.ExRd != 5'd0) &&
              ((bus.ExRd == bus.IdRs) || (bus.ExRd == bus.IdRt));

  // Gated with rst so that nothing but the defaults leave the block during reset.
  assign accept = rst && (state_q == ST_IDLE) && (bus.IntReq || pending_q) &&
                  bus.IE && bus.IdValid;

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_clear = 1'b0;
    idex_clear = 1'b0;
    pc_src_ov  = 2'b00;
    int_ack    = 1'b0;
    state_d    = state_q;
    epc_d      = epc_q;
    pending_d  = pending_q;

    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            // ID instruction is squashed (EPC re-executes it); LU is irrelevant.
            // A branch resolving this cycle still flushes IF/ID, and its target becomes EPC.
            int_ack    = 1'b1;
            idex_clear = 1'b1;
            ifid_clear = bus.BranchTaken;
            epc_d      = bus.BranchTaken ? bus.BranchTarget : bus.IdPC;
            pending_d  = 1'b0;
            state_d    = ST_FLUSH;
          end else if (bus.BranchTaken) begin
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_clear = 1'b1;
          end
        end

        ST_FLUSH: begin
          pc_src_ov  = 2'b01;
          ifid_clear = 1'b1;
          idex_clear = 1'b1;
          state_d    = ST_SERVICE;
        end

        ST_SERVICE: begin
          // No nesting: a new request is only remembered for after ERET.
          if (bus.IntReq) begin
            pending_d = 1'b1;
          end
          if (bus.BranchTaken) begin
            // Branch wins over an ERET sitting in ID; the ERET gets flushed.
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
          end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_clear = 1'b1;
          end else if (bus.IdEret && bus.IdValid) begin
            state_d = ST_RETURN;
          end
        end

        default: begin // ST_RETURN
          pc_src_ov  = 2'b10;
          ifid_clear = 1'b1;
          idex_clear = 1'b1;
          state_d    = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      epc_q     <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      pending_q <= pending_d;
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.IfIdWrite = ifid_write;
  assign bus.IfIdClear = ifid_clear;
  assign bus.IdExClear = idex_clear;
  assign bus.PCSrcOv   = pc_src_ov;
  assign bus.EPC       = epc_q;
  assign bus.IntAck    = int_ack;
  assign bus.InService = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {PCWrite, IfIdWrite, IfIdClear, IdExClear, PCSrcOv[1:0], EPC[31:0], IntAck, InService}
  logic [39:0] exp_q[$];
  string       name_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  event        mid_ev;

  function automatic logic [39:0] pack_out(logic pcw, logic ifw, logic ifc, logic iec,
                                           logic [1:0] ov, logic [31:0] epc,
                                           logic ack, logic svc);
    return {pcw, ifw, ifc, iec, ov, epc, ack, svc};
  endfunction

  // Monitor: each expectation pushed by the driver is compared at the next sample point.
  initial begin
    logic [39:0] act;
    logic [39:0] exp;
    string       nm;
    forever begin
      @(negedge clk or mid_ev);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.PCWrite, bus.IfIdWrite, bus.IfIdClear, bus.IdExClear, bus.PCSrcOv,
               bus.EPC, bus.IntAck, bus.InService};
        tests_run++;
        if (act !== exp) begin
          tests_failed++;
          $display("FAIL %s: actual pcw/ifw/ifc/iec=%b ov=%b epc=%h ack=%b svc=%b, required pcw/ifw/ifc/iec=%b ov=%b epc=%h ack=%b svc=%b",
                   nm, act[39:36], act[35:34], act[33:2], act[1], act[0],
                   exp[39:36], exp[35:34], exp[33:2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic expect_out(string nm, logic pcw, logic ifw, logic ifc, logic iec,
                            logic [1:0] ov, logic [31:0] epc, logic ack, logic svc);
    exp_q.push_back(pack_out(pcw, ifw, ifc, iec, ov, epc, ack, svc));
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.IdRs = 5'd0;  bus.IdRt = 5'd0;  bus.IdPC = 32'd0;  bus.IdValid = 1'b0;
    bus.IdEret = 1'b0; bus.ExRd = 5'd0; bus.ExMemRead = 1'b0; bus.ExRFWr = 1'b0;
    bus.BranchTaken = 1'b0; bus.BranchTarget = 32'd0; bus.IntReq = 1'b0; bus.IE = 1'b0;
  endtask

  task automatic set_lu();
    bus.ExMemRead = 1'b1; bus.ExRFWr = 1'b1; bus.ExRd = 5'd5; bus.IdRs = 5'd5;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any clock edge.
  task automatic async_reset(string nm);
    @(negedge clk);
    #2;
    rst = 1'b0;
    expect_out(nm, 1,1,0,0, 2'b00, 32'h0, 0, 0);
    #1;
    ->mid_ev;
  endtask

  initial begin
    rst = 1'b0;
    clr_in();

    // Reset holds defaults even with hazard and interrupt inputs active.
    step(); set_lu(); bus.IntReq = 1; bus.IE = 1; bus.IdValid = 1; bus.IdPC = 32'h44;
    expect_out("reset_defaults", 1,1,0,0, 2'b00, 32'h0, 0, 0);

    step(); rst = 1'b1; clr_in();
    expect_out("idle", 1,1,0,0, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); set_lu();
    expect_out("lu_rs", 0,0,0,1, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); set_lu(); bus.IdRs = 5'd0; bus.IdRt = 5'd5;
    expect_out("lu_rt", 0,0,0,1, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); set_lu(); bus.ExRd = 5'd0; bus.IdRs = 5'd0;
    expect_out("lu_r0_nostall", 1,1,0,0, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); set_lu(); bus.ExMemRead = 1'b0;
    expect_out("no_load", 1,1,0,0, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); set_lu(); bus.BranchTaken = 1; bus.BranchTarget = 32'h100;
    expect_out("lu_and_branch", 1,1,1,1, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); bus.IntReq = 1; bus.IE = 0; bus.IdValid = 1; bus.IdPC = 32'h20;
    expect_out("defer_ie", 1,1,0,0, 2'b00, 32'h0, 0, 0);
    step(); clr_in(); bus.IntReq = 1; bus.IE = 1; bus.IdValid = 0; bus.IdPC = 32'h24;
    expect_out("defer_valid", 1,1,0,0, 2'b00, 32'h0, 0, 0);

    // Acceptance with a simultaneous load-use: ID is squashed, no stall.
    step(); clr_in(); set_lu(); bus.IntReq = 1; bus.IE = 1; bus.IdValid = 1; bus.IdPC = 32'h40;
    expect_out("accept", 1,1,0,1, 2'b00, 32'h0, 1, 0);
    step(); clr_in();
    expect_out("flush", 1,1,1,1, 2'b01, 32'h40, 0, 0);
    step(); clr_in();
    expect_out("service", 1,1,0,0, 2'b00, 32'h40, 0, 1);
    step(); clr_in(); set_lu();
    expect_out("svc_lu", 0,0,0,1, 2'b00, 32'h40, 0, 1);
    // IntReq pulse while in service sets Pending; ERET held back by LU.
    step(); clr_in(); set_lu(); bus.IntReq = 1; bus.IE = 1; bus.IdValid = 1; bus.IdEret = 1;
    expect_out("svc_eret_lu", 0,0,0,1, 2'b00, 32'h40, 0, 1);
    step(); clr_in(); bus.IE = 1; bus.IdValid = 1; bus.IdEret = 1;
    bus.BranchTaken = 1; bus.BranchTarget = 32'h1234;
    expect_out("svc_eret_branch", 1,1,1,1, 2'b00, 32'h40, 0, 1);
    step(); clr_in(); bus.IntReq = 1; bus.IE = 1; bus.IdValid = 1; bus.IdEret = 1;
    expect_out("svc_eret_nonest", 1,1,0,0, 2'b00, 32'h40, 0, 1);
    step(); clr_in();
    expect_out("return", 1,1,1,1, 2'b10, 32'h40, 0, 0);
    // Re-acceptance from Pending alone, with a taken branch supplying EPC.
    step(); clr_in(); bus.IE = 1; bus.IdValid = 1; bus.IdPC = 32'h200;
    bus.BranchTaken = 1; bus.BranchTarget = 32'h80;
    expect_out("reaccept_pending", 1,1,1,1, 2'b00, 32'h40, 1, 0);
    step(); clr_in();
    expect_out("flush_branch_epc", 1,1,1,1, 2'b01, 32'h80, 0, 0);
    async_reset("rst_in_flush");

    // Second entry; reset while in service with Pending set must drop it.
    step(); rst = 1'b1; clr_in(); bus.IntReq = 1; bus.IE = 1; bus.IdValid = 1; bus.IdPC = 32'h10;
    expect_out("accept_after_rst", 1,1,0,1, 2'b00, 32'h0, 1, 0);
    step(); clr_in();
    expect_out("flush3", 1,1,1,1, 2'b01, 32'h10, 0, 0);
    step(); clr_in(); bus.IntReq = 1;
    expect_out("svc_pend", 1,1,0,0, 2'b00, 32'h10, 0, 1);
    async_reset("rst_in_service");
    step(); rst = 1'b1; clr_in(); bus.IE = 1; bus.IdValid = 1; bus.IdPC = 32'h30;
    expect_out("pending_discarded", 1,1,0,0, 2'b00, 32'h0, 0, 0);
    step(); clr_in();

    // Bounded drain of the scoreboard.
    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        step();
        budget--;
      end
      if (exp_q.size() != 0) begin
        tests_failed++;
        $display("FAIL drain: actual %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- IdRs  in  5  rs field of the instruction in ID.
- IdRt  in  5  rt field of the instruction in ID.
- IdPC  in  32  PC of the instruction in ID.
- IdValid  in  1  ID holds a real instruction, not a bubble.
- IdEret  in  1  instruction in ID is ERET.
- ExRd  in  5  destination register of the instruction in EX.
- ExMemRead  in  1  instruction in EX is a load.
- ExRFWr  in  1  instruction in EX writes the register file.
- BranchTaken  in  1  taken branch/jump resolved in EX.
- BranchTarget  in  32  target of the resolved branch.
- IntReq  in  1  external interrupt request, level.
- IE  in  1  interrupt enable from CP0.
- PCWrite  out  1  PC register write enable.
- IfIdWrite  out  1  WriteSig for the IF/ID register.
- IfIdClear  out  1  ClearSigIn for the IF/ID register.
- IdExClear  out  1  ClearSigIn for the ID/EX register.
- PCSrcOv  out  2  PC override: 00 normal, 01 handler vector, 10 EPC.
- EPC  out  32  saved return address.
- IntAck  out  1  one-cycle pulse on interrupt acceptance.
- InService  out  1  handler currently running.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, FLUSH, SERVICE and RETURN, plus registers EPC and Pending.
REQ-004 Load-use hazard (LU) SHALL be defined as ExMemRead && ExRFWr && ExRd!=0 && (ExRd==IdRs || ExRd==IdRt).
REQ-005 Defaults in every state SHALL be PCWrite=1, IfIdWrite=1, IfIdClear=0, IdExClear=0, PCSrcOv=00 and IntAck=0.
REQ-006 If BranchTaken=1, the block SHALL drive IfIdClear=1 and IdExClear=1 and SHALL ignore LU in that cycle (branch has priority).
REQ-007 If LU=1 and BranchTaken=0, the block SHALL drive PCWrite=0, IfIdWrite=0 and IdExClear=1 (one bubble per cycle of LU).
REQ-008 Acceptance: in IDLE, if (IntReq||Pending) && IE && IdValid, then on the next edge state SHALL become FLUSH, EPC SHALL load BranchTaken ? BranchTarget : IdPC, Pending SHALL clear, and IntAck SHALL be 1 combinationally in the accepting cycle.
REQ-009 If IdValid=0 or IE=0 while a request exists, acceptance SHALL be deferred with no state change; retry occurs every cycle.
REQ-010 Acceptance SHALL take priority over LU: the ID instruction is squashed, because EPC re-executes it.
REQ-011 In FLUSH, the block SHALL drive PCSrcOv=01, PCWrite=1, IfIdClear=1 and IdExClear=1, and SHALL move to SERVICE after exactly 1 cycle.
REQ-012 In SERVICE, InService SHALL be 1 and REQ-006/REQ-007 hazard handling SHALL apply.
REQ-013 In SERVICE, IntReq=1 SHALL set Pending and SHALL NOT cause nesting.
REQ-014 In SERVICE, IdEret && IdValid && !LU SHALL move to RETURN; ERET stalled by LU SHALL wait.
REQ-015 In RETURN, the block SHALL drive PCSrcOv=10, IfIdClear=1 and IdExClear=1, SHALL clear InService, and SHALL go to IDLE after 1 cycle.
REQ-016 When BranchTaken=1 coincides with IdEret in SERVICE, the branch SHALL win and the ERET is flushed.
REQ-017 EPC SHALL change only on acceptance.

Reset
REQ-018 While rst=0, the block SHALL hold state=IDLE, EPC=0, Pending=0 and InService=0; outputs then follow REQ-005.
REQ-019 Reset asserted in any state, including FLUSH or RETURN, SHALL take effect immediately and discard any pending interrupt.

Verification
REQ-020 ExMemRead=1, ExRFWr=1, ExRd=5, IdRs=5 for 1 cycle -> PCWrite=0, IfIdWrite=0, IdExClear=1 for that cycle; ExRd=0 -> no stall.
REQ-021 LU and BranchTaken together -> PCWrite=1, IfIdClear=1, IdExClear=1.
REQ-022 IDLE, IE=1, IdValid=1, IdPC=0x40, IntReq=1 -> IntAck pulse; next cycle PCSrcOv=01 with both clears; EPC=0x40; then InService=1.
REQ-023 Same as REQ-022 with BranchTaken=1, BranchTarget=0x80 -> EPC=0x80.
REQ-024 SERVICE, IntReq pulse, then IdEret -> RETURN (PCSrcOv=10), IDLE, then immediate re-acceptance from Pending.
REQ-025 rst=0 asserted during FLUSH -> IDLE, EPC=0, InService=0 with no clock edge required.
